// File: rtl/cpu_p_pkg.sv
// Shared definitions for the cpu_core_p subsystem: opcodes, FSM state
// encoding, instruction field positions and a small decode helper.
package cpu_p_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_BEQZ = 4'hB;
  localparam logic [3:0] OP_BNEZ = 4'hC;
  localparam logic [3:0] OP_ILL0 = 4'hD;
  localparam logic [3:0] OP_ILL1 = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Opcodes 1..9 produce a register result and update Z.
  function automatic logic writes_rd(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == OP_ILL0) || (op == OP_ILL1);
  endfunction

endpackage

// File: rtl/cpu_regfile_p.sv
// 8-entry register file for cpu_core_p.
// Ports: clk, rst_n (async active-low clear), three asynchronous read ports
// (rs1/rs2/rd address -> data), one synchronous write port (we/waddr/wdata).
// With R0_ZERO=1, r0 always reads 0 and writes to it are discarded.
module cpu_regfile_p #(
  parameter int DATA_W  = 8,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        rs1_addr_i,
  input  logic [2:0]        rs2_addr_i,
  input  logic [2:0]        rd_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [2:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [8];

  function automatic logic [DATA_W-1:0] rd_port(input logic [2:0] a);
    if (R0_ZERO && (a == 3'd0)) return '0;
    return regs_q[a];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (we_i && !(R0_ZERO && (waddr_i == 3'd0))) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rs1_data_o = rd_port(rs1_addr_i);
  assign rs2_data_o = rd_port(rs2_addr_i);
  assign rd_data_o  = rd_port(rd_addr_i);

endmodule

// File: rtl/cpu_core_p.sv
// Multi-cycle FETCH/DECODE/EXEC core with instruction-memory handshake.
// Ports: clk, rst (async active-low); run gates new fetches;
// imem_req/imem_addr/imem_rdata/imem_valid form the fetch handshake;
// pc_value, instr_out, alu_out, wb_en/wb_addr/wb_data, zero_flag,
// carry_flag, halted, illegal are observation outputs.
//
// state     | meaning
// ST_FETCH  | request instruction at pc while run=1, latch IR on accept
// ST_DECODE | capture rs1/rs2/rd operands from the register file
// ST_EXEC   | compute, write back, update flags and pc
// ST_HALT   | absorbing until reset (HALT or illegal opcode)
module cpu_core_p
  import cpu_p_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 5,
  parameter int NREG    = 8,  // field widths are fixed at 3 bits, so only 8 is meaningful
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [PC_W-1:0]   pc_value,
  output logic [15:0]       instr_out,
  output logic [DATA_W-1:0] alu_out,
  output logic              wb_en,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              halted,
  output logic              illegal
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, opd_q, opd_d;
  logic              z_q, z_d, c_q, c_d, ill_q, ill_d;

  logic [3:0]        op;
  logic [DATA_W-1:0] rs1_data, rs2_data, rd_data;
  logic [DATA_W-1:0] res, imm_ext;
  logic              cout, taken, accept, in_exec;

  assign op      = ir_q[OP_HI:OP_LO];
  assign imm_ext = DATA_W'(ir_q[IMM_HI:IMM_LO]);
  assign accept  = imem_req && imem_valid;
  assign in_exec = (state_q == ST_EXEC);

  cpu_regfile_p #(.DATA_W(DATA_W), .R0_ZERO(R0_ZERO)) u_rf (
    .clk        (clk),
    .rst_n      (rst),
    .rs1_addr_i (ir_q[RS1_HI:RS1_LO]),
    .rs2_addr_i (ir_q[RS2_HI:RS2_LO]),
    .rd_addr_i  (ir_q[RD_HI:RD_LO]),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .rd_data_o  (rd_data),
    .we_i       (wb_en),
    .waddr_i    (wb_addr),
    .wdata_i    (wb_data)
  );

  // ALU operates on operands captured in DECODE.
  always_comb begin
    res  = '0;
    cout = c_q;
    unique case (op)
      OP_ADD:  {cout, res} = {1'b0, opa_q} + {1'b0, opb_q};
      OP_SUB:  begin res = opa_q - opb_q; cout = (opa_q < opb_q); end
      OP_AND:  res = opa_q & opb_q;
      OP_OR:   res = opa_q | opb_q;
      OP_XOR:  res = opa_q ^ opb_q;
      OP_SHL:  res = {opa_q[DATA_W-2:0], 1'b0};
      OP_SHR:  res = {1'b0, opa_q[DATA_W-1:1]};
      OP_LDI:  res = imm_ext;
      OP_MOV:  res = opa_q;
      default: res = '0;
    endcase
  end

  always_comb begin
    unique case (op)
      OP_JMP:  taken = 1'b1;
      OP_BEQZ: taken = (opd_q == '0);
      OP_BNEZ: taken = (opd_q != '0);
      default: taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_FETCH;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH:  if (accept) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ((op == OP_HALT) || is_illegal(op)) ? ST_HALT : ST_FETCH;
      default:   state_d = ST_HALT;
    endcase
  end

  // Outputs; reset gates imem_req so a pending fetch is withdrawn at once.
  always_comb begin
    imem_req = rst && run && (state_q == ST_FETCH);
    halted   = (state_q == ST_HALT);
    alu_out  = in_exec ? res : '0;
    wb_en    = in_exec && writes_rd(op);
    wb_addr  = wb_en ? ir_q[RD_HI:RD_LO] : 3'd0;
    wb_data  = wb_en ? res : '0;
  end

  assign imem_addr  = pc_q;
  assign pc_value   = pc_q;
  assign instr_out  = ir_q;
  assign zero_flag  = z_q;
  assign carry_flag = c_q;
  assign illegal    = ill_q;

  // Datapath next-state
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    opa_d = opa_q;
    opb_d = opb_q;
    opd_d = opd_q;
    z_d   = z_q;
    c_d   = c_q;
    ill_d = ill_q;
    unique case (state_q)
      ST_FETCH: begin
        if (accept) begin
          ir_d = imem_rdata;
          if (is_illegal(imem_rdata[OP_HI:OP_LO])) ill_d = 1'b1;
        end
      end
      ST_DECODE: begin
        opa_d = rs1_data;
        opb_d = rs2_data;
        opd_d = rd_data;
      end
      ST_EXEC: begin
        pc_d = taken ? ir_q[PC_W-1:0] : pc_q + PC_W'(1);
        if (writes_rd(op)) z_d = (res == '0);
        if ((op == OP_ADD) || (op == OP_SUB)) c_d = cout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= '0;
      ir_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
      opd_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      opd_q <= opd_d;
      z_q   <= z_d;
      c_q   <= c_d;
      ill_q <= ill_d;
    end
  end

endmodule

// File: tb/tb_cpu_core_p.sv
// Scoreboard bench for cpu_core_p (DATA_W=8, PC_W=5, R0_ZERO=1).
module tb_cpu_core_p;

  localparam int DW = 8;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          imem_valid;
  logic [PW-1:0] pc_value;
  logic [15:0]   instr_out;
  logic [DW-1:0] alu_out;
  logic          wb_en;
  logic [2:0]    wb_addr;
  logic [DW-1:0] wb_data;
  logic          zero_flag, carry_flag, halted, illegal;

  cpu_core_p #(.DATA_W(DW), .PC_W(PW), .NREG(8), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .pc_value(pc_value), .instr_out(instr_out),
    .alu_out(alu_out), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Instruction memory model with programmable wait states.
  logic [15:0] imem [32];
  int          mem_wait = 0;
  int          wcnt = 0;
  logic        spur = 1'b0;
  assign imem_rdata = spur ? 16'hF000 : imem[imem_addr];
  assign imem_valid = spur || (imem_req && (wcnt >= mem_wait));
  always @(posedge clk) wcnt <= (imem_req && !imem_valid) ? wcnt + 1 : 0;

  int cyc = 0;
  always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

  typedef struct {
    int addr; int data; int z; int c; int wedge;
  } wb_t;
  wb_t exp_q[$];
  int  fq[$];

  int n_chk = 0, n_fail = 0;
  bit chk_fetch = 1'b0;
  int exp_wait = 0;
  int halt_cyc = -1;
  bit flag_pend = 1'b0;
  int pz = 0, pcf = 0;
  int req_len = 0;
  int req_addr = 0;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_wb(int a, int d, int z, int c, int e);
    wb_t t;
    t.addr = a; t.data = d; t.z = z; t.c = c; t.wedge = e;
    exp_q.push_back(t);
  endtask

  // Monitor: pops the scoreboard on every write strobe and fetch accept.
  always @(negedge clk) begin
    if (rst) begin
      if (flag_pend) begin
        chk("zero_flag", zero_flag, pz);
        chk("carry_flag", carry_flag, pcf);
        flag_pend = 1'b0;
      end
      if (wb_en) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_wb: got r%0d=0x%0h, expected no write", wb_addr, wb_data);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          chk("wb_addr", wb_addr, e.addr);
          chk("wb_data", wb_data, e.data);
          chk("alu_out", alu_out, e.data);
          if (e.wedge >= 0) chk("wb_edge", cyc + 1, e.wedge);
          pz = e.z; pcf = e.c; flag_pend = 1'b1;
        end
      end
      if (imem_req) begin
        if (req_len == 0) req_addr = int'(imem_addr);
        else if (chk_fetch) chk("imem_addr_stable", imem_addr, req_addr);
        req_len++;
        if (imem_valid) begin
          if (chk_fetch) begin
            if (fq.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL unexpected_fetch: got addr 0x%0h, expected none", imem_addr);
            end else chk("fetch_addr", imem_addr, fq.pop_front());
            chk("req_hold_cycles", req_len, exp_wait + 1);
          end
          req_len = 0;
        end
      end else req_len = 0;
      if (halted && halt_cyc < 0) halt_cyc = cyc;
    end
  end

  task automatic begin_test(int wt, bit fc);
    rst = 1'b0; run = 1'b0; spur = 1'b0;
    mem_wait = wt; exp_wait = wt; chk_fetch = fc;
    exp_q.delete(); fq.delete();
    halt_cyc = -1; flag_pend = 1'b0; req_len = 0;
    for (int i = 0; i < 32; i++) imem[i] = 16'hF000;
    @(negedge clk);
  endtask

  task automatic release_rst(bit r);
    @(posedge clk);
    #1 rst = 1'b1; run = r;
  endtask

  task automatic wait_halt(int budget);
    int n = 0;
    while (!halted && n < budget) begin @(negedge clk); n++; end
    chk("halt_reached", halted, 1);
    @(negedge clk);
  endtask

  task automatic load_basic();
    imem[0] = 16'h8205;  // LDI r1,5
    imem[1] = 16'h8403;  // LDI r2,3
    imem[2] = 16'h1650;  // ADD r3,r1,r2
    imem[3] = 16'hF000;  // HALT
  endtask

  initial begin
    // Basic program, reset state, write-back timing and halt cycle.
    begin_test(0, 1'b0);
    load_basic();
    run = 1'b1;
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_pc", pc_value, 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_alu_out", alu_out, 0);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_flags", {zero_flag, carry_flag}, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    exp_wb(1, 5, 0, 0, 3);
    exp_wb(2, 3, 0, 0, 6);
    exp_wb(3, 8, 0, 0, 9);
    release_rst(1'b1);
    wait_halt(100);
    chk("halt_cycle", halt_cyc, 12);
    repeat (5) @(negedge clk);
    chk("halt_sticky", halted, 1);
    chk("halt_no_req", imem_req, 0);
    chk("t1_sb_empty", exp_q.size(), 0);

    // ALU corner cases and flags.
    begin_test(0, 1'b0);
    imem[0] = 16'h82FF; imem[1] = 16'h8401; imem[2] = 16'h1650;
    imem[3] = 16'h2888; imem[4] = 16'h3A50; imem[5] = 16'h5C48;
    imem[6] = 16'h6E40; imem[7] = 16'h7FC0; imem[8] = 16'h4B60;
    exp_wb(1, 8'hFF, 0, 0, -1);
    exp_wb(2, 8'h01, 0, 0, -1);
    exp_wb(3, 8'h00, 1, 1, -1);
    exp_wb(4, 8'h02, 0, 1, -1);
    exp_wb(5, 8'h01, 0, 1, -1);
    exp_wb(6, 8'h00, 1, 1, -1);
    exp_wb(7, 8'hFE, 0, 1, -1);
    exp_wb(7, 8'h7F, 0, 1, -1);
    exp_wb(5, 8'h03, 0, 1, -1);
    release_rst(1'b1);
    wait_halt(200);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Branches and pc wrap, checked through the fetch address stream.
    begin_test(0, 1'b1);
    imem[0]  = 16'hC208;  // BNEZ r1,8
    imem[1]  = 16'hB010;  // BEQZ r0,0x10
    imem[16] = 16'hC005;  // BNEZ r0,5 (not taken)
    imem[17] = 16'h82AA;  // LDI r1,0xAA
    imem[18] = 16'hA01F;  // JMP 0x1F
    imem[31] = 16'h0000;  // NOP, pc wraps to 0
    imem[8]  = 16'hF000;
    fq = '{0, 1, 16, 17, 18, 31, 0, 8};
    exp_wb(1, 8'hAA, 0, 0, -1);
    release_rst(1'b1);
    wait_halt(200);
    chk("t3_fetch_empty", fq.size(), 0);
    chk("t3_sb_empty", exp_q.size(), 0);

    // Wait states and a spurious valid during DECODE.
    begin_test(3, 1'b1);
    imem[0] = 16'h825A; imem[1] = 16'hF000;
    fq = '{0, 1};
    exp_wb(1, 8'h5A, 0, 0, -1);
    release_rst(1'b1);
    repeat (2) @(negedge clk);
    chk("wait_ir_unlatched", instr_out, 0);
    chk("wait_req_held", imem_req, 1);
    begin
      int n = 0;
      while (!(imem_req && imem_valid) && n < 20) begin @(negedge clk); n++; end
    end
    chk("accept_seen", imem_req && imem_valid, 1);
    chk("pre_accept_ir", instr_out, 0);
    @(posedge clk); #1 spur = 1'b1;
    @(negedge clk);
    chk("spurious_ignored", instr_out, 16'h825A);
    @(posedge clk); #1 spur = 1'b0;
    wait_halt(100);
    chk("t4_fetch_empty", fq.size(), 0);
    chk("t4_sb_empty", exp_q.size(), 0);

    // run=0 holds fetch; r0 hardwired zero; illegal opcode.
    begin_test(0, 1'b0);
    imem[0] = 16'h8007; imem[1] = 16'h9200; imem[2] = 16'hD000;
    exp_wb(0, 7, 0, 0, -1);
    exp_wb(1, 0, 1, 0, -1);
    release_rst(1'b0);
    repeat (3) @(negedge clk);
    chk("run0_no_req", imem_req, 0);
    chk("run0_pc", pc_value, 0);
    chk("illegal_clear", illegal, 0);
    run = 1'b1;
    wait_halt(100);
    repeat (3) @(negedge clk);
    chk("illegal_set", illegal, 1);
    chk("illegal_halted", halted, 1);
    chk("t5_sb_empty", exp_q.size(), 0);

    // Reset during EXEC of ADD, then restart from address 0.
    begin_test(0, 1'b0);
    load_basic();
    exp_wb(1, 5, 0, 0, 3);
    exp_wb(2, 3, 0, 0, 6);
    release_rst(1'b1);
    repeat (8) @(posedge clk);
    #1 chk("exec_add_wb_en", wb_en, 1);
    #1 rst = 1'b0;
    #1;
    chk("midrst_wb_en", wb_en, 0);
    chk("midrst_alu_out", alu_out, 0);
    chk("midrst_req", imem_req, 0);
    chk("midrst_pc", pc_value, 0);
    chk("midrst_instr", instr_out, 0);
    chk("t6a_sb_empty", exp_q.size(), 0);
    begin_test(0, 1'b1);
    load_basic();
    fq = '{0, 1, 2, 3};
    exp_wb(1, 5, 0, 0, 3);
    exp_wb(2, 3, 0, 0, 6);
    exp_wb(3, 8, 0, 0, 9);
    release_rst(1'b1);
    wait_halt(100);
    chk("t6_fetch_empty", fq.size(), 0);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
